regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the register bank's single write port (`RegWrite` / `WriteRegister` / `WriteData`) between several writeback requesters, such as the ALU, the load unit and the debug/UART loader.

- Arbitration is round-robin with a valid/ready handshake per requester.
- A built-in clear sequencer zeroes registers 1..31 on command without asserting the bank's global reset.
- The block sits between the writeback sources and the register bank; its write-port outputs are registered.

## Interface
Parameters:
- `NUM_REQ`, 3: number of write requesters (2..8)
- `DATA_W`, 32: register data width
- `ADDR_W`, 5: register address width (32 registers)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester write request
- `req_addr`  in  NUM_REQ*ADDR_W  packed target register; requester i occupies bits [i*ADDR_W +: ADDR_W]
- `req_data`  in  NUM_REQ*DATA_W  packed write data, same packing
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`
- `clear_start`  in  1  request to zero registers 1..31
- `clear_busy`  out  1  clear sequence in progress
- `clear_done`  out  1  one-cycle pulse at the end of the clear sequence
- `RegWrite`  out  1  registered write enable to the bank
- `WriteRegister`  out  ADDR_W  registered write address
- `WriteData`  out  DATA_W  registered write data
- `grant_id`  out  clog2(NUM_REQ)  registered index of the requester that produced the current write

## Operation
- States: `IDLE` (arbitrating) and `CLEAR`.

IDLE:
- `req_ready` is combinational from `req_valid`, the state and the round-robin pointer.
- At most one bit of `req_ready` is high. It is the first valid requester at or after `ptr`, scanning upward with wrap-around.
- A granted requester with `req_addr == 0` completes its handshake, but `RegWrite` stays 0: the write is dropped, mirroring the bank's `$zero` protection.
- After every handshake, `ptr` becomes (granted index + 1) mod `NUM_REQ`. `ptr` is unchanged when there is no handshake.
- Requesters must not make `req_valid` depend on `req_ready`.
- `clear_start` high in IDLE has priority over requests:
  - all `req_ready` bits are 0 that cycle;
  - the next state is CLEAR, with index `idx` = 1.

CLEAR:
- All `req_ready` bits are 0.
- Each cycle, the outputs load RegWrite=1, WriteRegister=`idx`, WriteData=0, and `idx` increments.
- When `idx` = 31 is issued, the state returns to IDLE and `clear_done` pulses.
- `clear_start` during CLEAR is ignored. `ptr` is preserved across CLEAR.

Reset (`reset_n` low, any state):
- All outputs and `ptr` go to 0 immediately; state goes to IDLE.
- A clear in progress is abandoned and `clear_done` is not pulsed.

## Timing
- Handshake at edge N puts the write on the port during cycle N+1. The bank commits it at edge N+1.
- Sustained throughput is one write per cycle.
- Cycles with no handshake drive RegWrite=0. WriteRegister, WriteData and `grant_id` hold their last values.
- Clear sequence, with `clear_start` sampled at edge T:
  - `clear_busy` is high for cycles T..T+30 (31 cycles);
  - the port writes register k during cycle T+k, for k = 1..31;
  - `clear_done` is high during cycle T+31, coincident with the write of register 31.
- The first request grant after a clear is possible in cycle T+31.
- Reset values: `req_ready`=0, RegWrite=0, WriteRegister=0, WriteData=0, `grant_id`=0, `clear_busy`=0, `clear_done`=0. `ptr`=0, so requester 0 has highest priority first.

## Structure
- Package `regfile_ctrl_pkg` holds:
  - the state enum {`ST_IDLE`, `ST_CLEAR`};
  - `NUM_REGS`=32, `ZERO_REG`=0 and `LAST_REG`=31.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`) provides:
  - inputs `clk`, `reset_n`, `req`, `enable`, `advance`;
  - outputs a one-hot `grant` and `grant_idx`;
  - the `ptr` register internally.
- The top level holds the FSM, the clear counter and the output registers.

## Test plan
- Reset with all inputs active: every output is 0 during reset. After release with `req_valid`=3'b111, requester 0 is granted first, then 1, then 2, then 0 on successive cycles.
- Requester 1 alone writes addr 5, data 0xDEADBEEF: `req_ready`=3'b010 in the same cycle. Next cycle shows RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF, `grant_id`=1.
- Request to addr 0 with data 0x1234: the handshake completes, RegWrite stays 0 the next cycle, and `ptr` still advances.
- `clear_start` together with `req_valid`=3'b001 in IDLE: `req_ready`=0. The port then writes registers 1..31 with 0 on 31 consecutive cycles, `clear_done` pulses with register 31, and requester 0 is granted the following cycle.
- `reset_n` asserted while the port is writing register 10 of a clear: outputs drop to 0 asynchronously, `clear_done` never pulses, and the state is IDLE after release.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_ctrl_pkg : shared state type and register-bank constants         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package regfile_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;
  localparam int LAST_REG = 31;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant with a rotating priority pointer  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               j;

  // Scan upward from ptr with wrap-around; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (enable && !found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter : shares the register-bank write port, with clear  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic                        RegWrite,
  output logic [ADDR_W-1:0]           WriteRegister,
  output logic [DATA_W-1:0]           WriteData,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_idx;
  logic                arb_en;
  logic                clear_go;
  logic                clear_last;
  logic                handshake;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    gidx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .enable    (arb_en),
    .advance   (handshake),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign handshake = |(req_valid & grant);
  assign sel_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gidx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // clear_start in IDLE already counts as the first busy cycle (register 1 issued).
  always_comb begin
    state_nxt  = state;
    arb_en     = 1'b0;
    clear_busy = 1'b0;
    clear_go   = 1'b0;
    clear_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_start) begin
          clear_busy = 1'b1;
          clear_go   = 1'b1;
          state_nxt  = ST_CLEAR;
        end else begin
          arb_en = 1'b1;
        end
      end
      ST_CLEAR: begin
        clear_busy = 1'b1;
        if (clr_idx == ADDR_W'(LAST_REG)) begin
          clear_last = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!reset_n) begin
      arb_en     = 1'b0;
      clear_busy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      grant_id      <= '0;
      clear_done    <= 1'b0;
      clr_idx       <= '0;
    end else begin
      RegWrite   <= 1'b0;
      clear_done <= 1'b0;
      if (clear_go) begin
        RegWrite      <= 1'b1;
        WriteRegister <= ADDR_W'(1);
        WriteData     <= '0;
        clr_idx       <= ADDR_W'(2);
      end else if (state == ST_CLEAR) begin
        RegWrite      <= 1'b1;
        WriteRegister <= clr_idx;
        WriteData     <= '0;
        clr_idx       <= clr_idx + ADDR_W'(1);
        clear_done    <= clear_last;
      end else if (handshake) begin
        // Writes aimed at the zero register complete the handshake but are dropped.
        RegWrite      <= (sel_addr != ADDR_W'(ZERO_REG));
        WriteRegister <= sel_addr;
        WriteData     <= sel_data;
        grant_id      <= gidx;
      end
    end
  end

endmodule
`default_nettype wire
